write_operation: RTL and testbench

//  Write side of the synchronous FIFO: owns the DEPTH x DATA_WIDTH register bank, write pointer,

---
 rtl/fifo_pkg.sv | 17 +
 rtl/write_decoder.sv | 21 ++
 rtl/write_operation.sv | 151 +++++++++++++++
 tb/tb_write_operation.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the write-side state type.
// Used by the write side (write_operation, write_decoder) and the read side.
package fifo_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 3;
  localparam int DEPTH       = 1 << ADDR_WIDTH;
  // Occupancy needs one extra bit so that "completely full" (DEPTH) is representable.
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WR_ERROR = 2'd2
  } wr_state_t;

endpackage : fifo_pkg

// File: rtl/write_decoder.sv
// Write-address decoder: turns the write pointer into one load enable per
// register. At most one enable is high, and only when the write is accepted.
module write_decoder
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  accept,
  output logic [DEPTH-1:0]      load_en
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dec
      assign load_en[gi] = accept && (addr == ADDR_WIDTH'(gi));
    end
  endgenerate

endmodule : write_decoder

// File: rtl/write_operation.sv
// Write side of the synchronous FIFO: register bank, write pointer,
// occupancy count, full flag, and the ack/error status FSM.
// Optional feature: define WR_ALMOST_FULL_EN to add a registered
// almost_full output (high when occupancy >= DEPTH-1).
module write_operation
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        rd_done,
  output logic [DEPTH*DATA_WIDTH-1:0] reg_q,
  output logic [ADDR_WIDTH-1:0]       wr_ptr,
  output logic                        full,
  output logic                        wr_ack,
  output logic                        wr_err
`ifdef WR_ALMOST_FULL_EN
  ,
  output logic                        almost_full
`endif
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] bank_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q;
  wr_state_t             state_q, state_d;
  logic                  accept;
  logic [DEPTH-1:0]      load_en;

  // A write is taken only when the FIFO was not full before the edge;
  // a same-cycle pop never frees space for this write.
  assign accept = wr_en && !full_q;

  write_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_decoder (
    .addr   (wr_ptr_q),
    .accept (accept),
    .load_en(load_en)
  );

  // Register bank: each word loads din when its decoded enable is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load_en[i]) begin
          bank_q[i] <= din;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pack
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = bank_q[gi];
    end
  endgenerate

  // Next pointer and occupancy; a push and a pop in one cycle cancel out,
  // and a pop on an empty FIFO is ignored.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (accept && !rd_done) begin
      count_d = count_q + CW'(1);
    end else if (!accept && rd_done && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer, count and flags; flags are computed from the next count so
  // they line up with the count they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
    end
  end

`ifdef WR_ALMOST_FULL_EN
  logic almost_full_q;

  // Early warning: at most one free slot left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_d >= CW'(DEPTH - 1));
    end
  end

  assign almost_full = almost_full_q;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: every state can move to any other on each edge.
  always_comb begin
    state_d = IDLE;
    if (wr_en) begin
      state_d = full_q ? WR_ERROR : WRITE;
    end
  end

  // FSM Moore outputs: one-cycle status for the previous cycle's request.
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    case (state_q)
      WRITE:    wr_ack = 1'b1;
      WR_ERROR: wr_err = 1'b1;
      default: begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
      end
    endcase
  end

  assign wr_ptr = wr_ptr_q;
  assign full   = full_q;

endmodule : write_operation

// File: tb/tb_write_operation.sv
// Bench for write_operation: reference model plus directed scenarios.
// Build with WR_ALMOST_FULL_EN defined to also cover almost_full.
module tb_write_operation;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic          rd_done;
  logic [DW-1:0] din;
  logic [D*DW-1:0] reg_q;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          wr_ack;
  logic          wr_err;
`ifdef WR_ALMOST_FULL_EN
  logic          almost_full;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_operation #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (D)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .din    (din),
    .rd_done(rd_done),
    .reg_q  (reg_q),
    .wr_ptr (wr_ptr),
    .full   (full),
    .wr_ack (wr_ack),
    .wr_err (wr_err)
`ifdef WR_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return reg_q[i*DW +: DW];
  endfunction

  // Reference model: a plain memory, a pointer and an occupancy integer.
  logic [DW-1:0] m_mem [D];
  int m_ptr;
  int m_count;
  bit m_ack;
  bit m_err;

  always @(posedge clk or negedge reset_n) begin
    bit acc;
    if (!reset_n) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_ptr   = 0;
      m_count = 0;
      m_ack   = 0;
      m_err   = 0;
    end else begin
      acc = wr_en && (m_count < D);
      if (acc) begin
        m_mem[m_ptr] = din;
        m_ptr = (m_ptr + 1) % D;
      end
      if (acc && !rd_done) m_count++;
      else if (!acc && rd_done && m_count > 0) m_count--;
      m_ack = acc;
      m_err = wr_en && !acc;
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    logic [D*DW-1:0] e;
    if (reset_n === 1'b1) begin
      for (int i = 0; i < D; i++) e[i*DW +: DW] = m_mem[i];
      check("cmp_reg_q", reg_q, e);
      check("cmp_wr_ptr", wr_ptr, m_ptr[AW-1:0]);
      check("cmp_full", full, (m_count == D));
      check("cmp_wr_ack", wr_ack, m_ack);
      check("cmp_wr_err", wr_err, m_err);
`ifdef WR_ALMOST_FULL_EN
      check("cmp_almost_full", almost_full, (m_count >= D - 1));
`endif
    end
  end

  // One transaction: drive at the falling edge, let one rising edge pass.
  task automatic cycle(input bit we, input logic [DW-1:0] d, input bit rd);
    wr_en   = we;
    din     = d;
    rd_done = rd;
    @(posedge clk);
    @(negedge clk);
    $display("txn wr_en=%0b din=%h rd_done=%0b -> wr_ptr=%0d full=%0b ack=%0b err=%0b",
             we, d, rd, wr_ptr, full, wr_ack, wr_err);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] v;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_done = 1'b0;
    din     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_reg_q", reg_q, '0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_full", full, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_wr_err", wr_err, 0);
    reset_n = 1'b1;

    // Get some state in place, then reset in the middle of a write.
    cycle(1, 32'h12345678, 0);
    check("pre_ack", wr_ack, 1);
    check("pre_reg0", word(0), 32'h12345678);
    wr_en = 1'b1;
    din   = 32'hA5A5A5A5;
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_async_reg_q", reg_q, '0);
    check("t1_async_wr_ptr", wr_ptr, 0);
    check("t1_async_ack", wr_ack, 0);
    check("t1_async_full", full, 0);
    check("t1_async_err", wr_err, 0);
    @(posedge clk);
    @(negedge clk);
    check("t1_held_reg_q", reg_q, '0);
    reset_n = 1'b1;
    wr_en   = 1'b0;
    cycle(1, 32'hA5A5A5A5, 0);
    check("t1_first_reg0", word(0), 32'hA5A5A5A5);
    check("t1_first_ptr", wr_ptr, 1);
    check("t1_first_ack", wr_ack, 1);

    // Eight back-to-back writes fill the FIFO and wrap the pointer.
    pulse_reset();
    for (int k = 1; k <= D; k++) begin
      v = DW'(k) * 32'h11111111;
      cycle(1, v, 0);
      check("t2_ack", wr_ack, 1);
      if (k < D) check("t2_not_full", full, 0);
    end
    check("t2_full", full, 1);
    check("t2_ptr_wrap", wr_ptr, 0);
    for (int i = 0; i < D; i++) begin
      v = DW'(i + 1) * 32'h11111111;
      check("t2_reg", word(i), v);
    end

    // Write into a full FIFO is rejected and changes nothing.
    cycle(1, 32'hDEADBEEF, 0);
    check("t3_err", wr_err, 1);
    check("t3_ack", wr_ack, 0);
    check("t3_ptr", wr_ptr, 0);
    check("t3_full", full, 1);
    for (int i = 0; i < D; i++) begin
      v = DW'(i + 1) * 32'h11111111;
      check("t3_reg_kept", word(i), v);
    end
    cycle(0, 32'h0, 0);
    check("t3_idle_err", wr_err, 0);

    // Write and pop together while full: write rejected, count drops to 7.
    cycle(1, 32'h0BAD0BAD, 1);
    check("t4_err", wr_err, 1);
    check("t4_ack", wr_ack, 0);
    check("t4_full", full, 0);
    check("t4_ptr", wr_ptr, 0);
    check("t4_reg0", word(0), 32'h11111111);
    cycle(1, 32'h77770000, 0);
    check("t4_refill_ack", wr_ack, 1);
    check("t4_refill_full", full, 1);

    // Simultaneous push and pop at count 3 leaves the count at 3.
    pulse_reset();
    cycle(1, 32'h000000A0, 0);
    cycle(1, 32'h000000A1, 0);
    cycle(1, 32'h000000A2, 0);
    cycle(1, 32'h0000CAFE, 1);
    check("t5_reg3", word(3), 32'h0000CAFE);
    check("t5_ptr", wr_ptr, 4);
    check("t5_ack", wr_ack, 1);
    check("t5_full", full, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 32'hB0 + DW'(k), 0);
      if (k < 4) check("t5_count3_not_full", full, 0);
    end
    check("t5_count3_full", full, 1);
    for (int k = 0; k < D + 2; k++) cycle(0, 32'h0, 1);
    check("t5_empty_full", full, 0);
    check("t5_empty_ack", wr_ack, 0);
    for (int k = 0; k < D - 1; k++) cycle(1, 32'hC0 + DW'(k), 0);
    check("t5_no_underflow_7", full, 0);
    cycle(1, 32'hC7, 0);
    check("t5_no_underflow_8", full, 1);

`ifdef WR_ALMOST_FULL_EN
    // almost_full rises at seven entries and falls on the next pop.
    pulse_reset();
    for (int k = 0; k < D - 1; k++) begin
      cycle(1, 32'hE0 + DW'(k), 0);
      if (k < D - 2) check("t6_af_low", almost_full, 0);
    end
    check("t6_af_high", almost_full, 1);
    check("t6_full_low", full, 0);
    cycle(0, 32'h0, 1);
    check("t6_af_after_pop", almost_full, 0);
`endif

    cycle(0, 32'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_write_operation
